// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the AXI read arbiter slice.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package axi_rd_arb_pkg;

  // Arbiter FSM: idle/arbitrating, forwarding AR, routing R beats
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  // AXI4 AR field widths
  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;

  // Beat counter must reach 256 (ARLEN=255 -> 256 beats) without wrapping
  localparam int                  BEAT_CNT_W = 9;
  localparam logic [BEAT_CNT_W-1:0] BEAT_MAX = 9'd256;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Number of beats a burst of the given ARLEN carries
  function automatic logic [BEAT_CNT_W-1:0] burst_beats(input logic [AXI_LEN_W-1:0] len);
    return {1'b0, len} + 9'd1;
  endfunction

  function automatic logic resp_is_okay(input logic [1:0] resp);
    return resp == RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_arbiter.sv
// Round-robin request picker: lowest requesting index at or after ptr wins.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; grant follows req. AXI_RD_ARB_FIXED_PRIO_EN -> index 0 highest, no ptr port.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  int cand;

  // Walk candidates in priority order and take the first requester
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = 0;
    for (int off = 0; off < N; off++) begin
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
      cand = off;
`else
      cand = int'(ptr) + off;
      if (cand >= N) cand = cand - N;
`endif
      for (int i = 0; i < N; i++) begin
        if (!gnt_vld && (i == cand) && req[i]) begin
          gnt[i]  = 1'b1;
          gnt_idx = IDX_W'(i);
          gnt_vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// N-to-1 AXI4 read arbiter, one burst outstanding; checks RLAST vs ARLEN (sticky ERR_LEN).
// Latency: AR accept -> M_AXI_ARVALID 1 cycle; R path 0 cycles (combinational routing).
// Backpressure: losers hold ARVALID; R ready comes straight from the winner. Macro AXI_RD_ARB_FIXED_PRIO_EN selects fixed priority.
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 8,
  parameter int RDATA_WIDTH = 32,
  parameter int ID_LENGTH   = 4
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 S_AXI_ARESET,
  // requester AR side
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    REQ_ARADDR,
  input  logic [NUM_MASTERS*AXI_LEN_W-1:0]     REQ_ARLEN,
  input  logic [NUM_MASTERS*AXI_SIZE_W-1:0]    REQ_ARSIZE,
  input  logic [NUM_MASTERS*AXI_BURST_W-1:0]   REQ_ARBURST,
  input  logic [NUM_MASTERS*ID_LENGTH-1:0]     REQ_ARID,
  input  logic [NUM_MASTERS-1:0]               REQ_ARVALID,
  output logic [NUM_MASTERS-1:0]               REQ_ARREADY,
  // requester R side
  output logic [RDATA_WIDTH-1:0]               REQ_RDATA,
  output logic [ID_LENGTH-1:0]                 REQ_RID,
  output logic                                 REQ_RLAST,
  output logic [NUM_MASTERS-1:0]               REQ_RVALID,
  input  logic [NUM_MASTERS-1:0]               REQ_RREADY,
  // downstream AR
  output logic [ADDR_WIDTH-1:0]                M_AXI_ARADDR,
  output logic [AXI_LEN_W-1:0]                 M_AXI_ARLEN,
  output logic [AXI_SIZE_W-1:0]                M_AXI_ARSIZE,
  output logic [AXI_BURST_W-1:0]               M_AXI_ARBURST,
  output logic [ID_LENGTH-1:0]                 M_AXI_ARID,
  output logic                                 M_AXI_ARVALID,
  input  logic                                 M_AXI_ARREADY,
  // downstream R
  input  logic [RDATA_WIDTH-1:0]               M_AXI_RDATA,
  input  logic [ID_LENGTH-1:0]                 M_AXI_RID,
  input  logic                                 M_AXI_RLAST,
  input  logic                                 M_AXI_RVALID,
  output logic                                 M_AXI_RREADY,
  // status
  output logic [$clog2(NUM_MASTERS)-1:0]       GRANT_IDX,
  output logic                                 ERR_LEN
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  arb_state_t             state;
  logic [BEAT_CNT_W-1:0]  beat_cnt;
  logic [BEAT_CNT_W-1:0]  beat_nxt;
  logic [BEAT_CNT_W-1:0]  exp_beats;

  logic [NUM_MASTERS-1:0] arb_gnt;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_vld;

  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [AXI_LEN_W-1:0]   sel_len;
  logic [AXI_SIZE_W-1:0]  sel_size;
  logic [AXI_BURST_W-1:0] sel_burst;
  logic [ID_LENGTH-1:0]   sel_id;

  logic                   in_idle;
  logic                   in_data;
  logic                   r_hs;

`ifndef AXI_RD_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]       rr_ptr;
`endif

  assign in_idle = (state == ST_IDLE) && !S_AXI_ARESET;
  assign in_data = (state == ST_DATA);

  rr_arbiter #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req     (REQ_ARVALID),
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
    .ptr     (rr_ptr),
`endif
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Select the winning master's AR fields for latching
  always_comb begin
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_burst = '0;
    sel_id    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_addr  = REQ_ARADDR [i*ADDR_WIDTH  +: ADDR_WIDTH];
        sel_len   = REQ_ARLEN  [i*AXI_LEN_W   +: AXI_LEN_W];
        sel_size  = REQ_ARSIZE [i*AXI_SIZE_W  +: AXI_SIZE_W];
        sel_burst = REQ_ARBURST[i*AXI_BURST_W +: AXI_BURST_W];
        sel_id    = REQ_ARID   [i*ID_LENGTH   +: ID_LENGTH];
      end
    end
  end

  // Handshakes and R routing: only the granted master sees RVALID, and only in DATA
  always_comb begin
    REQ_ARREADY  = in_idle ? arb_gnt : '0;
    M_AXI_RREADY = in_data && REQ_RREADY[GRANT_IDX];
    REQ_RVALID   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      REQ_RVALID[i] = in_data && M_AXI_RVALID && (GRANT_IDX == IDX_W'(i));
    end
    REQ_RDATA = in_data ? M_AXI_RDATA : '0;
    REQ_RID   = in_data ? M_AXI_RID   : '0;
    REQ_RLAST = in_data && M_AXI_RLAST;
  end

  assign r_hs      = in_data && M_AXI_RVALID && M_AXI_RREADY;
  assign beat_nxt  = (beat_cnt == BEAT_MAX) ? BEAT_MAX : beat_cnt + 9'd1;
  assign exp_beats = burst_beats(M_AXI_ARLEN);

  // Arbiter FSM with registered AR outputs, beat counter and sticky length error
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state         <= ST_IDLE;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARLEN   <= '0;
      M_AXI_ARSIZE  <= '0;
      M_AXI_ARBURST <= '0;
      M_AXI_ARID    <= '0;
      M_AXI_ARVALID <= 1'b0;
      GRANT_IDX     <= '0;
      ERR_LEN       <= 1'b0;
      beat_cnt      <= '0;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
      rr_ptr        <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_vld) begin
            M_AXI_ARADDR  <= sel_addr;
            M_AXI_ARLEN   <= sel_len;
            M_AXI_ARSIZE  <= sel_size;
            M_AXI_ARBURST <= sel_burst;
            M_AXI_ARID    <= sel_id;
            M_AXI_ARVALID <= 1'b1;
            GRANT_IDX     <= arb_idx;
            beat_cnt      <= '0;
            state         <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            state         <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_nxt;
            if (M_AXI_RLAST) begin
              // Short or long burst: RLAST arrived on the wrong beat
              if (beat_nxt != exp_beats) ERR_LEN <= 1'b1;
              state <= ST_IDLE;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
              rr_ptr <= (GRANT_IDX == IDX_W'(NUM_MASTERS-1)) ? '0 : GRANT_IDX + 1'b1;
`endif
            end else if (beat_nxt == exp_beats) begin
              // Final expected beat without RLAST; keep routing until RLAST shows up
              ERR_LEN <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter with a transaction-level reference model.
// Latency: expects AR forwarded 1 cycle after grant, R routed in the same cycle.
// Backpressure: bench drives stalls on AR and R and checks ready propagation.
module tb_axi_rd_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int GW = $clog2(N);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N*AW-1:0]   req_araddr;
  logic [N*8-1:0]    req_arlen;
  logic [N*3-1:0]    req_arsize;
  logic [N*2-1:0]    req_arburst;
  logic [N*IW-1:0]   req_arid;
  logic [N-1:0]      req_arvalid;
  logic [N-1:0]      req_arready;
  logic [DW-1:0]     req_rdata;
  logic [IW-1:0]     req_rid;
  logic              req_rlast;
  logic [N-1:0]      req_rvalid;
  logic [N-1:0]      req_rready;
  logic [AW-1:0]     m_araddr;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;
  logic [IW-1:0]     m_arid;
  logic              m_arvalid;
  logic              m_arready;
  logic [DW-1:0]     m_rdata;
  logic [IW-1:0]     m_rid;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;
  logic [GW-1:0]     grant_idx;
  logic              err_len;

  axi_rd_arbiter #(
    .NUM_MASTERS (N),
    .ADDR_WIDTH  (AW),
    .RDATA_WIDTH (DW),
    .ID_LENGTH   (IW)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .REQ_ARADDR    (req_araddr),
    .REQ_ARLEN     (req_arlen),
    .REQ_ARSIZE    (req_arsize),
    .REQ_ARBURST   (req_arburst),
    .REQ_ARID      (req_arid),
    .REQ_ARVALID   (req_arvalid),
    .REQ_ARREADY   (req_arready),
    .REQ_RDATA     (req_rdata),
    .REQ_RID       (req_rid),
    .REQ_RLAST     (req_rlast),
    .REQ_RVALID    (req_rvalid),
    .REQ_RREADY    (req_rready),
    .M_AXI_ARADDR  (m_araddr),
    .M_AXI_ARLEN   (m_arlen),
    .M_AXI_ARSIZE  (m_arsize),
    .M_AXI_ARBURST (m_arburst),
    .M_AXI_ARID    (m_arid),
    .M_AXI_ARVALID (m_arvalid),
    .M_AXI_ARREADY (m_arready),
    .M_AXI_RDATA   (m_rdata),
    .M_AXI_RID     (m_rid),
    .M_AXI_RLAST   (m_rlast),
    .M_AXI_RVALID  (m_rvalid),
    .M_AXI_RREADY  (m_rready),
    .GRANT_IDX     (grant_idx),
    .ERR_LEN       (err_len)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending requests with their fields, rotation pointer, sticky error
  bit          pend    [N];
  logic [AW-1:0] f_addr[N];
  logic [7:0]  f_len   [N];
  logic [2:0]  f_size  [N];
  logic [1:0]  f_burst [N];
  logic [IW-1:0] f_id  [N];
  int          mptr = 0;
  bit          merr = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int m;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
      m = k;
`else
      m = (mptr + k) % N;
`endif
      if (pend[m]) return m;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int m);
    logic [N-1:0] v;
    v = '0;
    v[m] = 1'b1;
    return v;
  endfunction

  task automatic set_req(input int m, input logic [AW-1:0] a, input logic [7:0] l, input logic [IW-1:0] id);
    pend[m]    = 1'b1;
    f_addr[m]  = a;
    f_len[m]   = l;
    f_size[m]  = 3'($urandom);
    f_burst[m] = 2'($urandom);
    f_id[m]    = id;
    req_araddr [m*AW +: AW] = a;
    req_arlen  [m*8  +: 8]  = l;
    req_arsize [m*3  +: 3]  = f_size[m];
    req_arburst[m*2  +: 2]  = f_burst[m];
    req_arid   [m*IW +: IW] = id;
    req_arvalid[m] = 1'b1;
  endtask

  task automatic set_rand(input int m);
    if (!pend[m]) set_req(m, AW'($urandom), 8'($urandom_range(0, 7)), IW'($urandom));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arready"}, req_arready, '0);
    chk({tag, "_rvalid"},  req_rvalid,  '0);
    chk({tag, "_arvalid"}, m_arvalid,   0);
    chk({tag, "_m_rready"}, m_rready,   0);
    chk({tag, "_grant"},   grant_idx,   0);
    chk({tag, "_err"},     err_len,     0);
  endtask

  // One arbitration round: grant, AR forward (with stall), R beats (with stalls/errors/reset)
  // rlast_at: 0 = correct RLAST, >0 = RLAST on that beat, <0 = random RLAST beat
  task automatic do_round(input int ar_stall, input int rlast_at, input int hold_beat,
                          input int hold_cyc, input int rst_beat);
    int g, nb, beat, hold_left, budget;
    logic rv, rdy, last;
    logic [DW-1:0] cur;
    logic [N-1:0] rr;
    g = pick();
    if (g < 0) return;
    // IDLE cycle: stray downstream RVALID must be ignored
    m_rvalid  = 1'b1;
    m_rdata   = DW'($urandom);
    m_rlast   = 1'b1;
    m_arready = 1'b0;
    req_rready = '1;
    #1;
    chk("arready_grant", req_arready, onehot(g));
    chk("idle_rvalid",   req_rvalid, '0);
    chk("idle_m_rready", m_rready, 0);
    chk("idle_arvalid",  m_arvalid, 0);
    chk("err_hold",      err_len, merr);
    step();
    pend[g] = 1'b0;
    req_arvalid[g] = 1'b0;
    // ADDR phase
    for (int s = 0; s <= ar_stall; s++) begin
      m_arready = (s == ar_stall);
      #1;
      chk("ar_valid",   m_arvalid, 1);
      chk("ar_addr",    m_araddr, f_addr[g]);
      chk("ar_len",     m_arlen, f_len[g]);
      chk("ar_size",    m_arsize, f_size[g]);
      chk("ar_burst",   m_arburst, f_burst[g]);
      chk("ar_id",      m_arid, f_id[g]);
      chk("grant_idx",  grant_idx, g);
      chk("addr_arready", req_arready, '0);
      chk("addr_rvalid",  req_rvalid, '0);
      chk("addr_m_rready", m_rready, 0);
      step();
    end
    m_arready = 1'b0;
    // DATA phase
    if (rlast_at > 0)      nb = rlast_at;
    else if (rlast_at < 0) nb = $urandom_range(1, int'(f_len[g]) + 2);
    else                   nb = int'(f_len[g]) + 1;
    beat = 1;
    hold_left = hold_cyc;
    cur = DW'($urandom);
    budget = 0;
    while (beat <= nb && budget < 400) begin
      budget++;
      if (rst_beat != 0 && beat == rst_beat) begin
        rst = 1'b1;
        m_rvalid = 1'b1;
        m_rlast = 1'b0;
        req_arvalid = '0;
        for (int m = 0; m < N; m++) pend[m] = 1'b0;
        step();
        chk_reset_outputs("midrst");
        rst = 1'b0;
        m_rvalid = 1'b0;
        mptr = 0;
        merr = 1'b0;
        step();
        return;
      end
      if (hold_left > 0 && beat == hold_beat) begin
        rv = 1'b1;
        rdy = 1'b0;
      end else begin
        rv  = ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 3) != 0);
      end
      rr = N'($urandom);
      rr[g] = rdy;
      req_rready = rr;
      m_rvalid = rv;
      m_rdata  = cur;
      m_rid    = f_id[g];
      last     = (beat == nb);
      m_rlast  = last;
      #1;
      chk("rvalid_route", req_rvalid, rv ? onehot(g) : '0);
      chk("m_rready",     m_rready, rdy);
      chk("data_arready", req_arready, '0);
      if (rv) begin
        chk("rdata", req_rdata, cur);
        chk("rid",   req_rid, f_id[g]);
        chk("rlast", req_rlast, last);
      end
      step();
      if (rv && rdy) begin
        if (last && beat != int'(f_len[g]) + 1) merr = 1'b1;
        if (!last && beat == int'(f_len[g]) + 1) merr = 1'b1;
        chk("err_len", err_len, merr);
        beat++;
        cur = DW'($urandom);
      end else if (rv && beat == hold_beat && hold_left > 0) begin
        hold_left--;
      end
    end
    if (beat <= nb) chk("burst_budget", beat, nb + 1);
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
    mptr = (g + 1) % N;
`endif
  endtask

  initial begin
    rst = 1'b1;
    req_araddr = '0; req_arlen = '0; req_arsize = '0; req_arburst = '0; req_arid = '0;
    req_arvalid = '0; req_rready = '0;
    m_arready = 1'b0; m_rdata = '0; m_rid = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    for (int m = 0; m < N; m++) pend[m] = 1'b0;
    repeat (3) step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Single master, fixed fields
    set_req(0, 8'h10, 8'd3, 4'd5);
    do_round(0, 0, 0, 0, 0);

    // Contention: M0 and M1 together, then re-request
    set_rand(0); set_rand(1);
    do_round(0, 0, 0, 0, 0);
    set_rand(0);
    do_round(1, 0, 0, 0, 0);
    set_rand(1);
    do_round(0, 0, 0, 0, 0);
    repeat (N) do_round(0, 0, 0, 0, 0);

    // R backpressure on M1: 5 stalled cycles on beat 2
    set_req(1, AW'($urandom), 8'd3, IW'($urandom));
    do_round(0, 0, 2, 5, 0);

    // Length error: ARLEN=1, RLAST on beat 3
    set_req(0, AW'($urandom), 8'd1, IW'($urandom));
    do_round(0, 3, 0, 0, 0);

    // Downstream ARREADY held low for 10 cycles, M2 waiting alongside
    set_rand(0);
    set_rand(2);
    do_round(10, 0, 0, 0, 0);

    // Reset during beat 2 of an ARLEN=7 burst
    set_req(1, AW'($urandom), 8'd7, IW'($urandom));
    do_round(0, 0, 0, 0, 2);

    // Post-reset contention restarts from index 0
    set_rand(0); set_rand(1);
    do_round(0, 0, 0, 0, 0);
    repeat (N) do_round(0, 0, 0, 0, 0);

    // Randomized rounds
    for (int r = 0; r < 60; r++) begin
      bit any;
      any = 1'b0;
      for (int m = 0; m < N; m++) begin
        if ($urandom_range(0, 1) == 1) set_rand(m);
        if (pend[m]) any = 1'b1;
      end
      if (!any) set_rand($urandom_range(0, N-1));
      do_round($urandom_range(0, 3), ($urandom_range(0, 4) == 0) ? -1 : 0, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
